// File: rtl/fetch_unit.sv
// Fetch stage: round-robin warp scheduler issuing one aligned two-instruction
// i-cache request at a time and presenting the returned instructions to decode.
module fetch_unit #(
    parameter int unsigned NUM_WARP         = 8,
    parameter int unsigned NUM_WARP_LOG     = 3,
    parameter int unsigned SIZE_PC          = 32,
    parameter int unsigned SIZE_INSTRUCTION = 64
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 warpStart_i,
    input  logic [NUM_WARP_LOG-1:0]              warpStartId_i,
    input  logic [SIZE_PC-1:0]                   warpStartPC_i,
    input  logic                                 warpStop_i,
    input  logic [NUM_WARP_LOG-1:0]              warpStopId_i,
    input  logic                                 redirectValid_i,
    input  logic [NUM_WARP_LOG-1:0]              redirectWarp_i,
    input  logic [SIZE_PC-1:0]                   redirectPC_i,
    input  logic                                 stall_i,
    output logic                                 icReqValid_o,
    output logic [SIZE_PC-1:0]                   icReqAddr_o,
    input  logic                                 icRespValid_i,
    input  logic [2*SIZE_INSTRUCTION-1:0]        icRespData_i,
    output logic [NUM_WARP_LOG-1:0]              instWarp_o,
    output logic                                 instPacket0Valid_o,
    output logic [SIZE_INSTRUCTION+SIZE_PC-1:0]  instPacket0_o,
    output logic                                 instPacket1Valid_o,
    output logic [SIZE_INSTRUCTION+SIZE_PC-1:0]  instPacket1_o
);

    localparam int unsigned PKT_W = SIZE_INSTRUCTION + SIZE_PC;

    typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

    state_e                  state_q;
    logic [SIZE_PC-1:0]      pc_q [NUM_WARP];
    logic [NUM_WARP-1:0]     active_q;
    logic [NUM_WARP_LOG-1:0] rr_ptr_q;
    logic [NUM_WARP_LOG-1:0] cur_warp_q;
    logic                    squash_q;

    // Skid register for a response that arrives while decode is stalled
    logic [NUM_WARP_LOG-1:0] skid_warp_q;
    logic                    skid_v0_q;
    logic                    skid_v1_q;
    logic [PKT_W-1:0]        skid_p0_q;
    logic [PKT_W-1:0]        skid_p1_q;

    logic                    sel_found;
    logic [NUM_WARP_LOG-1:0] sel_warp;
    logic                    out_free;
    logic                    issue;
    logic                    resp_take;
    logic                    kill_cur;
    logic                    kill_sel;
    logic                    kill_skid;
    logic                    kill_out;
    logic [SIZE_PC-1:0]      cur_pc;
    logic [SIZE_PC-1:0]      line_next;
    logic [PKT_W-1:0]        new_p0;
    logic [PKT_W-1:0]        new_p1;
    logic                    new_v1;

    assign out_free = (!instPacket0Valid_o && !instPacket1Valid_o) || !stall_i;
    assign issue    = (state_q == StIdle) && sel_found && out_free;

    // A warp is hit when it is redirected or stopped this cycle
    assign kill_cur  = (redirectValid_i && (redirectWarp_i == cur_warp_q)) ||
                       (warpStop_i && (warpStopId_i == cur_warp_q));
    assign kill_sel  = (redirectValid_i && (redirectWarp_i == sel_warp)) ||
                       (warpStop_i && (warpStopId_i == sel_warp));
    assign kill_skid = (redirectValid_i && (redirectWarp_i == skid_warp_q)) ||
                       (warpStop_i && (warpStopId_i == skid_warp_q));
    assign kill_out  = (redirectValid_i && (redirectWarp_i == instWarp_o)) ||
                       (warpStop_i && (warpStopId_i == instWarp_o));

    assign resp_take = (state_q == StWait) && icRespValid_i && !squash_q && !kill_cur;

    assign cur_pc    = pc_q[cur_warp_q];
    assign line_next = {cur_pc[SIZE_PC-1:4], 4'b0000} + SIZE_PC'(16);

    // Round-robin pick: first active warp after rr_ptr_q, wrapping
    always_comb begin
        logic [NUM_WARP_LOG-1:0] cand;
        sel_found = 1'b0;
        sel_warp  = '0;
        cand      = '0;
        for (int i = 1; i <= int'(NUM_WARP); i++) begin
            cand = rr_ptr_q + NUM_WARP_LOG'(i);
            if (!sel_found && active_q[cand]) begin
                sel_found = 1'b1;
                sel_warp  = cand;
            end
        end
    end

    // Split the returned line according to which half of it the PC points at
    always_comb begin
        new_p0 = '0;
        new_p1 = '0;
        new_v1 = 1'b0;
        if (!cur_pc[3]) begin
            new_p0 = {icRespData_i[SIZE_INSTRUCTION-1:0], cur_pc};
            new_p1 = {icRespData_i[2*SIZE_INSTRUCTION-1:SIZE_INSTRUCTION],
                      cur_pc + SIZE_PC'(8)};
            new_v1 = 1'b1;
        end else begin
            new_p0 = {icRespData_i[2*SIZE_INSTRUCTION-1:SIZE_INSTRUCTION], cur_pc};
        end
    end

    // Per-warp PC and active bits; later assignments take priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < int'(NUM_WARP); w++) begin
                pc_q[w] <= '0;
            end
            active_q <= '0;
        end else begin
            if (resp_take) begin
                pc_q[cur_warp_q] <= line_next;
            end
            if (warpStart_i) begin
                pc_q[warpStartId_i]     <= warpStartPC_i;
                active_q[warpStartId_i] <= 1'b1;
            end
            if (warpStop_i) begin
                active_q[warpStopId_i] <= 1'b0;
            end
            if (redirectValid_i) begin
                pc_q[redirectWarp_i] <= redirectPC_i;
            end
        end
    end

    // Fetch FSM with registered request, output and skid registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= StIdle;
            rr_ptr_q           <= NUM_WARP_LOG'(NUM_WARP - 1);
            cur_warp_q         <= '0;
            squash_q           <= 1'b0;
            icReqValid_o       <= 1'b0;
            icReqAddr_o        <= '0;
            instWarp_o         <= '0;
            instPacket0Valid_o <= 1'b0;
            instPacket0_o      <= '0;
            instPacket1Valid_o <= 1'b0;
            instPacket1_o      <= '0;
            skid_warp_q        <= '0;
            skid_v0_q          <= 1'b0;
            skid_v1_q          <= 1'b0;
            skid_p0_q          <= '0;
            skid_p1_q          <= '0;
        end else begin
            icReqValid_o <= 1'b0;
            // Packets are consumed when decode is ready, or dropped if their warp is hit
            if (!stall_i || kill_out) begin
                instPacket0Valid_o <= 1'b0;
                instPacket1Valid_o <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (issue) begin
                        icReqValid_o <= 1'b1;
                        icReqAddr_o  <= {pc_q[sel_warp][SIZE_PC-1:4], 4'b0000};
                        cur_warp_q   <= sel_warp;
                        rr_ptr_q     <= sel_warp;
                        // PC changes under a request being issued make it stale
                        squash_q     <= kill_sel;
                        state_q      <= StWait;
                    end
                end
                StWait: begin
                    if (icRespValid_i) begin
                        squash_q <= 1'b0;
                        if (squash_q || kill_cur) begin
                            state_q <= StIdle;
                        end else if (out_free) begin
                            instWarp_o         <= cur_warp_q;
                            instPacket0Valid_o <= 1'b1;
                            instPacket0_o      <= new_p0;
                            instPacket1Valid_o <= new_v1;
                            instPacket1_o      <= new_p1;
                            state_q            <= StIdle;
                        end else begin
                            skid_warp_q <= cur_warp_q;
                            skid_v0_q   <= 1'b1;
                            skid_p0_q   <= new_p0;
                            skid_v1_q   <= new_v1;
                            skid_p1_q   <= new_p1;
                            state_q     <= StHold;
                        end
                    end else if (kill_cur) begin
                        squash_q <= 1'b1;
                    end
                end
                StHold: begin
                    if (kill_skid) begin
                        skid_v0_q <= 1'b0;
                        skid_v1_q <= 1'b0;
                        state_q   <= StIdle;
                    end else if (!stall_i) begin
                        instWarp_o         <= skid_warp_q;
                        instPacket0Valid_o <= skid_v0_q;
                        instPacket0_o      <= skid_p0_q;
                        instPacket1Valid_o <= skid_v1_q;
                        instPacket1_o      <= skid_p1_q;
                        skid_v0_q          <= 1'b0;
                        skid_v1_q          <= 1'b0;
                        state_q            <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front-end stage of the SIMD pipeline: the transmitting end of the fetch-to-decode interface.
- Holds a per-warp PC and active bit, and picks a warp round-robin.
- Issues one aligned two-instruction request to the instruction cache and drives the warp id, two instruction+PC packets and per-packet valids into the decode stage.
- Supports decode backpressure, per-warp branch redirect and warp start/stop.

Parameters:
NUM_WARP, 8, number of hardware warps
NUM_WARP_LOG, 3, log2(NUM_WARP)
SIZE_PC, 32, PC width (byte address)
SIZE_INSTRUCTION, 64, instruction width; one instruction = 8 bytes

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous active-high reset
warpStart_i  in  1  activate warpStartId_i at warpStartPC_i
warpStartId_i  in  NUM_WARP_LOG  warp to start
warpStartPC_i  in  SIZE_PC  start PC
warpStop_i  in  1  deactivate warpStopId_i
warpStopId_i  in  NUM_WARP_LOG  warp to stop
redirectValid_i  in  1  branch redirect
redirectWarp_i  in  NUM_WARP_LOG  redirected warp
redirectPC_i  in  SIZE_PC  new PC
stall_i  in  1  decode cannot accept; hold outputs
icReqValid_o  out  1  i-cache request, one-cycle pulse
icReqAddr_o  out  SIZE_PC  request address, always PC with bits[3:0]=0
icRespValid_i  in  1  response strobe
icRespData_i  in  2*SIZE_INSTRUCTION  [63:0] instruction at addr, [127:64] at addr+8
instWarp_o  out  NUM_WARP_LOG  warp of output packets
instPacket0Valid_o  out  1  packet 0 valid
instPacket0_o  out  SIZE_INSTRUCTION+SIZE_PC  {instruction, PC}, PC in low SIZE_PC bits
instPacket1Valid_o  out  1  packet 1 valid
instPacket1_o  out  SIZE_INSTRUCTION+SIZE_PC  {instruction, PC}

Behaviour:
- Reset (async):
  - All PCs 0, active mask 0, rrPtr = NUM_WARP-1, FSM IDLE, squash 0.
  - All outputs 0.
- FSM states: IDLE, WAIT, HOLD.
- IDLE:
  - If any warp is active and the output register is free (both out valids 0, or stall_i=0), select the first active warp scanning rrPtr+1, rrPtr+2, … with wrap.
  - Pulse icReqValid_o for 1 cycle with icReqAddr_o = PC & ~15.
  - Latch the selected warp, set rrPtr to it, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT, on icRespValid_i:
  - If squash=1: drop the data, clear squash, go to IDLE.
  - Otherwise, if PC[3]=0: packet0 = {data[63:0], PC}, packet1 = {data[127:64], PC+8}, both valid.
  - If PC[3]=1: packet0 = {data[127:64], PC}, valid; packet1 invalid, payload 0.
  - Warp PC becomes (PC & ~15)+16.
  - If the output register is free, load it the next cycle and go to IDLE; else place the result in the skid register and go to HOLD.
- HOLD: when stall_i=0, move the skid register to the outputs and go to IDLE.
- Output register:
  - While stall_i=1, outputs hold.
  - When stall_i=0 and no new load, valids clear after one cycle; each packet is presented exactly once.
- Redirect, applied the next cycle, highest priority over the sequential PC update:
  - PC[redirectWarp_i] = redirectPC_i.
  - If that warp has a request in WAIT, set squash.
  - If that warp's packets sit in the skid register, invalidate them and go to IDLE.
  - If that warp's packets sit in the output register under stall, clear the out valids.
  - Redirect does not change the active bit.
- Start sets the active bit and the PC.
- Stop clears the active bit and squashes or invalidates that warp's in-flight or held packets, following the same rules as redirect.
- Start and stop on the same warp in the same cycle: stop wins.
- Redirect coincident with an icRespValid_i for the same warp: the response is dropped and the PC becomes redirectPC_i.
- Reset mid-WAIT: everything clears. A late icRespValid_i arriving in IDLE is ignored.
- One request is outstanding at most; latency is 1 cycle from response to valid outputs.

Test Plan:
- Reset, then start warp 2 at PC 0x100. Required: icReqAddr_o=0x100; response {B,A} → instWarp_o=2, pkt0={A,0x100}, pkt1={B,0x108}, both valid for 1 cycle; next request at 0x110.
- Start warp 0 at 0x208. Required: request 0x200; response {B,A} → pkt0={B,0x208} valid, pkt1 valid=0; next request 0x210.
- Warps 1, 3, 6 active. Required: request order 1, 3, 6, 1, 3 with wraparound.
- Hold stall_i=1 for 5 cycles while outputs are valid, with a second response arriving meanwhile. Required: outputs stable; no new icReqValid_o beyond the skid; after release, both packet sets appear in order, one cycle each.
- Redirect warp 2 to 0x400 while its request is in WAIT. Required: the returned data is never output; the next request for warp 2 is 0x400.
- Stop warp 5 while its packets are held under stall. Required: out valids drop the next cycle; warp 5 is never selected again until restarted.
